// File: rtl/psmac_seq_if.sv
// psmac_seq_if: request/response bundle between a PSMAC client and the psmac_seq sequencer
interface psmac_seq_if #(parameter int ACC_W = 20);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       prec;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             a_signed;
    logic             b_signed;
    logic             acc_en;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    modport master (output in_valid, prec, a, b, a_signed, b_signed, acc_en, out_ready,
                    input  in_ready, out_valid, result);
    modport slave  (input  in_valid, prec, a, b, a_signed, b_signed, acc_en, out_ready,
                    output in_ready, out_valid, result);
endinterface

// File: rtl/psmac_seq.sv
// psmac_seq: 2-bit-digit precision-scalable MAC sequencer; define PSMAC_SEQ_ZSKIP_EN to skip zero digit pairs
module psmac_seq #(parameter int ACC_W = 20) (
    input  logic       clk,
    input  logic       rst,
    psmac_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       prec_q;
    logic [7:0]       a_q, b_q;
    logic             as_q, bs_q;
    logic [3:0]       ij_q, ij_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             accept, last;
    logic [3:0]       start, nxt;
    logic [1:0]       da, db, sel;
    logic [5:0]       xa, xb, pw;
    logic [3:0]       p, sh;
    logic [ACC_W-1:0] pe;

    assign accept = bus.in_valid && state_q == IDLE;

`ifdef PSMAC_SEQ_ZSKIP_EN
    function automatic logic [15:0] mask_f(input logic [1:0] pr, input logic [7:0] x, input logic [7:0] y);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                mask_f[i*4+j] = i <= int'(pr) && j <= int'(pr) && x[2*i +: 2] != 2'b0 && y[2*j +: 2] != 2'b0;
    endfunction
    // lowest set pair index at or above from, as {found, {i, j}}
    function automatic logic [4:0] seek_f(input logic [15:0] m, input logic [4:0] from);
        seek_f = '0;
        for (int k = 15; k >= 0; k--)
            if (m[k] && 5'(k) >= from) seek_f = {1'b1, 4'(k)};
    endfunction
    logic [4:0] nxt_s;
    assign start = 4'(seek_f(mask_f(bus.prec, bus.a, bus.b), 5'd0));
    assign nxt_s = seek_f(mask_f(prec_q, a_q, b_q), {1'b0, ij_q} + 5'd1);
    assign nxt   = nxt_s[3:0];
    assign last  = !nxt_s[4];
`else
    assign start = '0;
    assign nxt   = ij_q[1:0] == prec_q ? {ij_q[3:2] + 2'd1, 2'd0} : ij_q + 4'd1;
    assign last  = ij_q[3:2] == prec_q && ij_q[1:0] == prec_q;
`endif

    // digit-pair multiplier: low 4 bits of the product of the extended digits
    always_comb begin
        da  = a_q[{ij_q[3:2], 1'b0} +: 2];
        db  = b_q[{ij_q[1:0], 1'b0} +: 2];
        sel = {as_q && ij_q[3:2] == prec_q, bs_q && ij_q[1:0] == prec_q};
        xa  = {{4{sel[1] & da[1]}}, da};
        xb  = {{4{sel[0] & db[1]}}, db};
        pw  = xa * xb;
        p   = pw[3:0];
        pe  = sel != 2'b00 ? {{(ACC_W-4){p[3]}}, p} : {{(ACC_W-4){1'b0}}, p};
        sh  = {1'b0, ij_q[3:2], 1'b0} + {1'b0, ij_q[1:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ij_q    <= '0;
            acc_q   <= '0;
            prec_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            as_q    <= 1'b0;
            bs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ij_q    <= ij_d;
            acc_q   <= acc_d;
            if (accept) begin
                prec_q <= bus.prec;
                a_q    <= bus.a;
                b_q    <= bus.b;
                as_q   <= bus.a_signed;
                bs_q   <= bus.b_signed;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ij_d    = ij_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = RUN;
                ij_d    = start;
                acc_d   = bus.acc_en ? acc_q : '0;
            end
            RUN: begin
                acc_d   = acc_q + (pe << sh);
                ij_d    = last ? ij_q : nxt;
                state_d = last ? DONE : RUN;
            end
            DONE:    state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.out_valid = state_q == DONE;
        bus.result    = acc_q;
    end
endmodule
